sopc_test_ctrl: RTL

SOPC_TEST_CTRL -- requirements
Module: sopc_test_ctrl

---
 rtl/sopc_test_ctrl_pkg.sv | 16 +
 rtl/sopc_test_ctrl_sat_counter.sv | 30 +++
 rtl/sopc_test_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/sopc_test_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sopc_test_ctrl_pkg : shared reset polarity and signature defaults     |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package sopc_test_ctrl_pkg;

  // SOPC reset polarity: core held in reset when high
  localparam logic RST_ENABLE  = 1'b1;
  localparam logic RST_DISABLE = 1'b0;

  localparam logic [31:0] DEF_SIG_ADDR  = 32'h0000_FFF0;
  localparam logic [31:0] DEF_PASS_CODE = 32'h0000_0001;

endpackage
`default_nettype wire

// File: rtl/sopc_test_ctrl_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_counter : up counter with clear, sticks at all-ones               |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         max
);

  assign max = &q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && !max) begin
      q <= q + W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/sopc_test_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sopc_test_ctrl : holds the SOPC in reset, runs it, and snoops the     |
// | end-of-test signature write or times out.        Revision 1.0         |
// +----------------------------------------------------------------------+
module sopc_test_ctrl
  import sopc_test_ctrl_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES = 10,
  parameter int unsigned TIMEOUT_CYCLES  = 150,
  parameter int unsigned CNT_W           = 32,
  parameter logic [31:0] SIG_ADDR        = DEF_SIG_ADDR,
  parameter logic [31:0] PASS_CODE       = DEF_PASS_CODE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             mem_we,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_data,
  output logic             core_rst,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [31:0]      sig_value
);

  localparam logic [1:0] C_ST_HOLD = 2'd0;
  localparam logic [1:0] C_ST_RUN  = 2'd1;
  localparam logic [1:0] C_ST_END  = 2'd2;

  localparam logic [7:0]       C_HOLD_LAST = 8'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_RUN_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0] r_state;
  logic [1:0] r_sync;
  logic [7:0] w_hold_q;
  logic       w_hold_max;
  logic       w_run_max;
  logic       w_in_hold;
  logic       w_in_run;
  logic       w_hold_done;
  logic       w_sig_hit;
  logic       w_to_hit;

  // Release edge is resynchronised before the hold count may start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], 1'b1};
    end
  end

  assign w_in_hold   = (r_state == C_ST_HOLD);
  assign w_in_run    = (r_state == C_ST_RUN);
  assign w_hold_done = w_in_hold && r_sync[1] && (w_hold_q == C_HOLD_LAST);
  assign w_sig_hit   = w_in_run && mem_we && (mem_addr == SIG_ADDR);
  assign w_to_hit    = w_in_run && !w_sig_hit && (cycle_count == C_RUN_LAST);

  sat_counter #(.W(8)) u_hold_cnt (
    .clk (clk),
    .rst (rst),
    .clr (restart),
    .en  (w_in_hold && r_sync[1] && !w_hold_done && !w_hold_max && !restart),
    .q   (w_hold_q),
    .max (w_hold_max)
  );

  // Count freezes on the cycle that ends the run so the final value holds
  sat_counter #(.W(CNT_W)) u_run_cnt (
    .clk (clk),
    .rst (rst),
    .clr (restart),
    .en  (w_in_run && !w_sig_hit && !w_to_hit && !w_run_max && !restart),
    .q   (cycle_count),
    .max (w_run_max)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= C_ST_HOLD;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      sig_value <= '0;
    end else if (restart) begin
      r_state   <= C_ST_HOLD;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      sig_value <= '0;
    end else begin
      case (r_state)
        C_ST_HOLD: begin
          if (w_hold_done) r_state <= C_ST_RUN;
        end
        C_ST_RUN: begin
          if (w_sig_hit) begin
            sig_value <= mem_data;
            done      <= 1'b1;
            pass      <= (mem_data == PASS_CODE);
            r_state   <= C_ST_END;
          end else if (w_to_hit) begin
            done    <= 1'b1;
            timeout <= 1'b1;
            r_state <= C_ST_END;
          end
        end
        C_ST_END: begin
          r_state <= C_ST_END;
        end
        default: begin
          r_state <= C_ST_HOLD;
        end
      endcase
    end
  end

  assign core_rst = w_in_run ? RST_DISABLE : RST_ENABLE;
  assign running  = w_in_run;

endmodule
`default_nettype wire
